psum_add_tree: RTL and testbench
================================

PSUM_ADD_TREE -- requirements
Module: psum_add_tree

Interface
REQ-001 SHALL have parameter DWIDTH, default 25, operand and result width in bits (range 8..32).
REQ-002 SHALL have parameter NTAP, default 3, number of PE product inputs (range 2..16).
REQ-003 SHALL define derived constants: LAT = clog2(NTAP+1) tree stages; GW = DWIDTH + LAT internal guard width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_valid  input  1  pe_data, psum_in and acc_* qualified this cycle.
REQ-007 pe_data  input  NTAP*DWIDTH  packed signed PE products; tap i is bits [i*DWIDTH +: DWIDTH].
REQ-008 psum_in  input  DWIDTH  signed incoming partial sum.
REQ-009 acc_en  input  1  add this beat's result into the held output accumulator.
REQ-010 acc_last  input  1  marks the final beat of an accumulation group.
REQ-011 psum_out  output  DWIDTH  signed result, registered.
REQ-012 out_valid  output  1  psum_out is a new result this cycle.
REQ-013 out_last  output  1  acc_last delayed in step with out_valid.
REQ-014 ovf  output  1  sticky: a result exceeded the DWIDTH signed range.

Function
REQ-015 SHALL sign-extend all NTAP+1 operands (taps plus psum_in) to GW bits before any addition.
REQ-016 SHALL form a binary adder tree of LAT registered stages.
  - Each stage pairwise-adds its operands.
  - An odd leftover operand passes through registered, unchanged.
REQ-017 SHALL register a final accumulate stage after the tree.
  - acc_en=0: acc <= tree_sum.
  - acc_en=1: acc <= acc + tree_sum, in GW bits.
REQ-018 SHALL give fixed latency LAT+1 cycles from in_valid to out_valid (NTAP=3: 3 cycles).
REQ-019 SHALL accept one beat per cycle, no backpressure; bubbles (in_valid=0) SHALL propagate as out_valid=0.
REQ-020 SHALL carry acc_en and acc_last alongside valid through every stage.
REQ-021 Datapath stage registers SHALL hold when their valid bit is 0.
REQ-022 acc and psum_out SHALL update only on a valid beat at the final stage.
REQ-023 out_last SHALL be 1 only when out_valid=1 and that beat had acc_last=1.
REQ-024 After an out_last beat, the next valid beat SHALL start a new group: its acc_en is treated as 0 regardless of the input.
REQ-025 psum_out SHALL be acc reduced to DWIDTH per REQ-030/031.
REQ-026 ovf SHALL set when the reduced value differs from acc.
  - ovf stays set until reset.
  - acc itself is never clipped.

Reset
REQ-027 On rst=1, SHALL clear immediately, without a clock: all stage registers, valid/tag pipeline, acc, psum_out=0, out_valid=0, out_last=0, ovf=0.
REQ-028 Beats in flight when rst asserts SHALL be discarded; no out_valid for them after rst deasserts.
REQ-029 First in_valid after rst deasserts SHALL be treated as a group start.

Configuration
REQ-030 With macro PSUM_ADD_SAT_EN defined, psum_out SHALL saturate to the DWIDTH signed range (max 2^(DWIDTH-1)-1, min -2^(DWIDTH-1)).
REQ-031 Without PSUM_ADD_SAT_EN, psum_out SHALL be the low DWIDTH bits of acc (two's-complement wrap); ovf behaves identically in both builds.

Verification (DWIDTH=25, NTAP=3 unless stated)
REQ-032 Taps 1,2,3, psum_in 4, acc_en=0, in_valid at cycle 0 -> psum_out=10, out_valid=1 at cycle 3 only.
REQ-033 Three back-to-back beats, each taps 1,1,1, psum_in 1, acc_en=1, acc_last on 3rd -> outputs 4, 8, 12 on consecutive cycles, out_last only with 12; next beat with acc_en=1 restarts at its own sum.
REQ-034 All taps and psum_in = 2^24-1, acc_en=0 -> SAT build: psum_out=16777215, ovf=1; wrap build: psum_out = low 25 bits of 67108860 = 0x1FFFFFC, ovf=1.
REQ-035 Alternate in_valid 1/0 with taps -5,-6,7, psum_in 0 -> out_valid pattern 1/0 delayed 3 cycles, each result -4.
REQ-036 Assert rst mid-stream with two beats in flight -> outputs 0 immediately, no out_valid for the discarded beats.
REQ-037 NTAP=8 build, taps 1..8, psum_in 0 -> psum_out=36 after LAT+1=5 cycles.

Source files
------------

// File: rtl/psum_add_tree.sv
// ---------------------------------------------------------------------------
// psum_add_tree
//
// Reduces NTAP signed PE products plus one incoming partial sum through a
// registered binary adder tree. A final accumulate stage either loads the
// tree sum or adds it to the held accumulator. Fixed latency is LAT+1 cycles.
// There is no backpressure, and bubbles flow through as out_valid=0.
//
// Parameters
//   DWIDTH    operand and result width in bits (8..32)
//   NTAP      number of PE product inputs (2..16)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  pe_data, psum_in, acc_en and acc_last are qualified this cycle
//   pe_data   packed signed products; tap i is bits [i*DWIDTH +: DWIDTH]
//   psum_in   signed incoming partial sum
//   acc_en    add this beat's tree sum into the held accumulator
//   acc_last  final beat of an accumulation group
//   psum_out  registered signed result, acc reduced to DWIDTH
//   out_valid psum_out holds a new result this cycle
//   out_last  the result's beat carried acc_last
//   ovf       sticky: some result did not fit the DWIDTH signed range
//
// Build option
//   PSUM_ADD_SAT_EN  when defined, psum_out saturates to the DWIDTH signed
//                    range; otherwise psum_out wraps (low DWIDTH bits of acc).
//                    ovf behaves the same way in both builds.
// ---------------------------------------------------------------------------
module psum_add_tree #(
    parameter int DWIDTH = 25,
    parameter int NTAP   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NTAP*DWIDTH-1:0]   pe_data,
    input  logic [DWIDTH-1:0]        psum_in,
    input  logic                     acc_en,
    input  logic                     acc_last,
    output logic [DWIDTH-1:0]        psum_out,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     ovf
);

    localparam int NOPS = NTAP + 1;
    localparam int LAT  = $clog2(NOPS);
    localparam int GW   = DWIDTH + LAT;

    // Operand count at tree level s (level 0 is the sign-extended inputs).
    function automatic int cnt(input int s);
        return (NOPS + (1 << s) - 1) >> s;
    endfunction

    // Operand offset of level s within the flattened level vector.
    function automatic int off(input int s);
        int o = 0;
        for (int k = 0; k < s; k++) o += cnt(k);
        return o;
    endfunction

    localparam int NALL = off(LAT + 1);   // levels 0..LAT
    localparam int NTR  = NALL - NOPS;    // registered levels 1..LAT

    logic [NOPS*GW-1:0] ops;      // level 0, combinational
    logic [NTR*GW-1:0]  tr;       // levels 1..LAT, registered
    logic [NALL*GW-1:0] lv;       // all levels, flattened

    logic [LAT:1] v_q, en_q, last_q;
    logic [LAT:0] v_all, en_all, last_all;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        ops = '0;
        for (int i = 0; i < NTAP; i++) begin
            ops[i*GW +: GW] = {{LAT{pe_data[i*DWIDTH + DWIDTH-1]}}, pe_data[i*DWIDTH +: DWIDTH]};
        end
        ops[NTAP*GW +: GW] = {{LAT{psum_in[DWIDTH-1]}}, psum_in};
    end

    assign lv       = {tr, ops};
    assign v_all    = {v_q, in_valid};
    assign en_all   = {en_q, acc_en};
    assign last_all = {last_q, acc_last};

    // Tree stages: pairwise sums; an odd leftover operand is registered as-is.
    // Data and tags of a stage hold while the beat entering it is a bubble.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tr     <= '0;
            v_q    <= '0;
            en_q   <= '0;
            last_q <= '0;
        end else begin
            for (int s = 1; s <= LAT; s++) begin
                v_q[s] <= v_all[s-1];
                if (v_all[s-1]) begin
                    en_q[s]   <= en_all[s-1];
                    last_q[s] <= last_all[s-1];
                    for (int j = 0; j < cnt(s); j++) begin
                        if (2*j + 1 < cnt(s-1)) begin
                            tr[(off(s)-NOPS+j)*GW +: GW] <= lv[(off(s-1)+2*j)*GW +: GW]
                                                          + lv[(off(s-1)+2*j+1)*GW +: GW];
                        end else begin
                            tr[(off(s)-NOPS+j)*GW +: GW] <= lv[(off(s-1)+2*j)*GW +: GW];
                        end
                    end
                end
            end
        end
    end

    // Final accumulate stage.
    logic [GW-1:0]     tree_sum, acc, acc_next;
    logic [DWIDTH-1:0] wrap_val, red_val;
    logic              new_grp;   // next valid beat opens a group
    logic              fits;

    assign tree_sum = lv[off(LAT)*GW +: GW];
    assign acc_next = (en_all[LAT] && !new_grp) ? acc + tree_sum : tree_sum;
    assign wrap_val = acc_next[DWIDTH-1:0];
    // The value fits iff sign-extending its low DWIDTH bits rebuilds acc.
    assign fits     = (acc_next == {{LAT{wrap_val[DWIDTH-1]}}, wrap_val});

`ifdef PSUM_ADD_SAT_EN
    assign red_val = fits ? wrap_val
                   : (acc_next[GW-1] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                     : {1'b0, {(DWIDTH-1){1'b1}}});
`else
    assign red_val = wrap_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            psum_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            new_grp   <= 1'b1;
        end else begin
            out_valid <= v_all[LAT];
            out_last  <= v_all[LAT] & last_all[LAT];
            if (v_all[LAT]) begin
                acc      <= acc_next;
                psum_out <= red_val;
                new_grp  <= last_all[LAT];
                if (!fits) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_add_tree.sv
module tb_psum_add_tree;

    localparam int DW   = 25;
    localparam int NT   = 3;
    localparam int LATC = 3;                 // LAT+1 for NTAP=3
    localparam longint SMAX = (64'sd1 <<< (DW-1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (DW-1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic [NT*DW-1:0]  pe_data  = '0;
    logic [DW-1:0]     psum_in  = '0;
    logic              acc_en   = 1'b0;
    logic              acc_last = 1'b0;
    logic [DW-1:0]     psum_out;
    logic              out_valid, out_last, ovf;

    logic              in_valid8 = 1'b0;
    logic [8*DW-1:0]   pe_data8  = '0;
    logic [DW-1:0]     psum_in8  = '0;
    logic              acc_en8   = 1'b0;
    logic              acc_last8 = 1'b0;
    logic [DW-1:0]     psum_out8;
    logic              out_valid8, out_last8, ovf8;

    psum_add_tree #(.DWIDTH(DW), .NTAP(NT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pe_data(pe_data),
        .psum_in(psum_in), .acc_en(acc_en), .acc_last(acc_last),
        .psum_out(psum_out), .out_valid(out_valid), .out_last(out_last), .ovf(ovf)
    );

    psum_add_tree #(.DWIDTH(DW), .NTAP(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .pe_data(pe_data8),
        .psum_in(psum_in8), .acc_en(acc_en8), .acc_last(acc_last8),
        .psum_out(psum_out8), .out_valid(out_valid8), .out_last(out_last8), .ovf(ovf8)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [DW-1:0] val;
        logic        last;
        logic        ovf;
    } exp_t;
    exp_t sbq[$];

    // Reference model of the accumulate stage.
    longint m_acc = 0;
    bit     m_new = 1'b1;
    bit     m_ovf = 1'b0;

    function automatic logic [DW-1:0] reduce(longint a);
        logic [63:0] b;
`ifdef PSUM_ADD_SAT_EN
        if (a > SMAX) a = SMAX;
        else if (a < SMIN) a = SMIN;
`endif
        b = a;
        return b[DW-1:0];
    endfunction

    task automatic drive(input bit v, input int t0, input int t1, input int t2,
                         input int p, input bit en, input bit last);
        longint s;
        @(negedge clk);
        in_valid = v;
        pe_data  = {DW'(t2), DW'(t1), DW'(t0)};
        psum_in  = DW'(p);
        acc_en   = en;
        acc_last = last;
        if (v) begin
            s = longint'(t0) + longint'(t1) + longint'(t2) + longint'(p);
            if (en && !m_new) m_acc = m_acc + s;
            else              m_acc = s;
            m_new = last;
            if (m_acc > SMAX || m_acc < SMIN) m_ovf = 1'b1;
            sbq.push_back('{cyc + LATC, reduce(m_acc), last, m_ovf});
        end
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        acc_en   = 1'b0;
        acc_last = 1'b0;
        for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_assert++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending, want 0", sbq.size());
        end
    endtask

    // Scoreboard monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                n_assert++;
                if (sbq.size() == 0 || sbq[0].due != cyc) begin
                    n_fail++;
                    $display("FAIL out_valid_timing: out_valid=1 at cycle %0d, pending=%0d due=%0d",
                             cyc, sbq.size(), (sbq.size() > 0) ? sbq[0].due : -1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    n_assert++;
                    if (psum_out !== e.val) begin
                        n_fail++;
                        $display("FAIL psum_out: got %h want %h (cycle %0d)", psum_out, e.val, cyc);
                    end
                    n_assert++;
                    if (out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL out_last: got %b want %b (cycle %0d)", out_last, e.last, cyc);
                    end
                    n_assert++;
                    if (ovf !== e.ovf) begin
                        n_fail++;
                        $display("FAIL ovf: got %b want %b (cycle %0d)", ovf, e.ovf, cyc);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                n_assert++;
                n_fail++;
                $display("FAIL out_valid_missing: out_valid=0 at cycle %0d, want 1", cyc);
                void'(sbq.pop_front());
            end
            if (!out_valid && out_last) begin
                n_assert++;
                n_fail++;
                $display("FAIL out_last_alone: out_last=1 with out_valid=0 at cycle %0d", cyc);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        n_assert++;
        if (psum_out !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got psum_out=%h out_valid=%b out_last=%b ovf=%b want all 0",
                     tag, psum_out, out_valid, out_last, ovf);
        end
    endtask

    task automatic check_final(input string tag, input logic [DW-1:0] want);
        n_assert++;
        if (psum_out !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, psum_out, want);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b1, 1, 2, 3, 4, 1'b0, 1'b1);
        drain();
        check_final("single_beat", DW'(10));
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1, 1, 1, 1, 1'b1, 1'b0);
        drive(1'b1, 1, 1, 1, 1, 1'b1, 1'b0);
        drive(1'b1, 1, 1, 1, 1, 1'b1, 1'b1);
        drain();
        check_final("b2b_group_end", DW'(12));
        drive(1'b1, 1, 1, 1, 1, 1'b1, 1'b1);
        drain();
        check_final("b2b_restart", DW'(4));
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, -5, -6, 7, 0, 1'b0, 1'b0);
            drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        end
        drain();
        check_final("bubble_result", DW'(-4));
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            drive(($urandom_range(3) != 0),
                  int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
                  int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
                  $urandom_range(1) == 1, $urandom_range(3) == 0);
        end
        drive(1'b1, 0, 0, 0, 0, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_overflow();
        int m;
        m = (1 << 24) - 1;
        drive(1'b1, m, m, m, m, 1'b0, 1'b1);
        drain();
`ifdef PSUM_ADD_SAT_EN
        check_final("overflow_value", 25'd16777215);
`else
        check_final("overflow_value", 25'h1FFFFFC);
`endif
        drive(1'b1, 1, 1, 1, 1, 1'b0, 1'b1);
        drain();
        n_assert++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", ovf);
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 3, 3, 3, 3, 1'b0, 1'b0);
        drive(1'b1, 5, 5, 5, 5, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        m_acc = 0;
        m_new = 1'b1;
        m_ovf = 1'b0;
        #1 check_reset_outputs("reset_async_clear");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        // Group start after reset: acc_en=1 must not add onto stale state.
        drive(1'b1, 2, 2, 2, 2, 1'b1, 1'b1);
        drain();
        check_final("post_reset_start", DW'(8));
    endtask

    task automatic test_ntap8();
        int c0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) pe_data8[i*DW +: DW] = DW'(i + 1);
        psum_in8  = '0;
        in_valid8 = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) in_valid8 = 1'b0;
            n_assert++;
            if (out_valid8 !== (cyc - c0 == 5)) begin
                n_fail++;
                $display("FAIL ntap8_valid: out_valid8=%b at +%0d cycles, want %b",
                         out_valid8, cyc - c0, (cyc - c0 == 5));
            end
            if (cyc - c0 == 5) begin
                n_assert++;
                if (psum_out8 !== DW'(36)) begin
                    n_fail++;
                    $display("FAIL ntap8_sum: got %0d want 36", psum_out8);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bubbles();
        test_random();
        test_overflow();
        test_reset_inflight();
        test_ntap8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
